tinyalu_arbiter: RTL and testbench
==================================

Name: tinyalu_arbiter

Overview:
- Shares one tinyalu between two independent requesters (ports 0 and 1).
- Arbitrates round-robin and latches the granted operands. Drives the ALU start/op handshake, waits for done, then returns the 16-bit result to the winner.
- Handles no_op and illegal opcodes locally, and enforces a done timeout so a hung ALU cannot deadlock either requester.
- Sits between the tester/BFM-side requesters and the tinyalu instance in top.

Parameters:
TIMEOUT_CYCLES, 16, maximum cycles alu_start may stay high without alu_done before the transaction is aborted with an error (legal range 4..255)

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  arbiter accepts requester 0 this cycle
req0_A  input  8  operand A, requester 0
req0_B  input  8  operand B, requester 0
req0_op  input  3  opcode, requester 0
rsp0_valid  output  1  one-cycle response strobe, requester 0
rsp0_result  output  16  result, requester 0
rsp0_err  output  1  illegal op or timeout, requester 0
req1_valid, req1_ready, req1_A, req1_B, req1_op  as for port 0
rsp1_valid, rsp1_result, rsp1_err  as for port 0
alu_A  output  8  to tinyalu A
alu_B  output  8  to tinyalu B
alu_op  output  3  to tinyalu op
alu_start  output  1  to tinyalu start
alu_done  input  1  from tinyalu done
alu_result  input  16  from tinyalu result
busy  output  1  high whenever state != IDLE

Behaviour:
- Opcodes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul. Codes 101, 110 and 111 are illegal (111 rst_op is never forwarded).
- Reset (async, reset_n=0):
  - state=IDLE, last_grant=1 (port 0 wins first tie).
  - All outputs 0; operand and result registers 0.
  - Reset asserted mid-transaction drops alu_start immediately; the in-flight request is lost and no response is issued.
- IDLE:
  - reqN_ready is combinational: high only in IDLE, for the granted port.
  - Grant rule: if only one valid, grant it; if both valid, grant the port != last_grant.
  - On valid&&ready at an edge: latch A, B, op and the port id, update last_grant, then branch:
    - legal ALU op (001..100) -> EXEC
    - no_op -> RESP, result=0, err=0
    - illegal -> RESP, result=0, err=1
- EXEC:
  - alu_start=1; alu_A/alu_B/alu_op driven from latches and held stable the whole time start is high.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - On the first edge alu_done=1: capture alu_result, err=0, go to RESP.
  - If counter reaches TIMEOUT_CYCLES-1 without done: go to RESP, result=0, err=1. A late alu_done arriving in RESP or IDLE is ignored.
- RESP:
  - alu_start=0, which guarantees at least one idle cycle between ALU operations.
  - rspN_valid=1 for exactly one cycle on the latched port; rspN_result/rspN_err are valid only with it; no backpressure.
  - Next state is IDLE; the new grant is evaluated in the following cycle.
- Outside EXEC, alu_start=0 and alu_A/alu_B/alu_op hold their last latched values.
- Latency: accept edge -> start high next cycle. rsp_valid is high in the cycle after the done edge.
- Local-op latency: accept edge -> rsp_valid in the next cycle.
- Throughput: one transaction in flight; minimum 3 cycles per legal op.
- A requester must hold valid/A/B/op stable until ready. The other port's ready stays 0 while busy.

Test Plan:
1. Single add: req0 A=8'h05, B=8'h03, op=001 -> exactly one alu_start window; rsp0_valid with result=16'h0008, err=0; rsp1_valid never asserted.
2. Back-to-back contention: both ports valid continuously, port0 mul A=8'hFF,B=8'hFF; port1 xor A=8'hAA,B=8'h55.
   - Grants alternate 0,1,0,1.
   - rsp0 returns 16'hFE01, rsp1 returns 16'h00FF.
   - alu_start low at least one cycle between operations.
3. no_op and illegal: req1 op=000 -> rsp1_valid the cycle after accept, result=0, err=0, alu_start never high; req1 op=111 -> result=0, err=1, alu_start never high.
4. Timeout: ALU model withholds done; req0 add accepted.
   - alu_start stays high exactly TIMEOUT_CYCLES cycles (16).
   - rsp0_err=1, result=0.
   - A late done pulse is ignored; the next req0 and 8'h0F,8'h33 op=010 returns 16'h0003.
5. Reset mid-mul: assert reset_n=0 two cycles into EXEC -> alu_start, busy and all rsp outputs 0 asynchronously. After release, no stale response; first tie grants port 0.
6. Operand stability: req0 changes its inputs after acceptance during EXEC -> alu_A/alu_B/alu_op remain at the latched values until done.

Source files
------------

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin front end that shares one tinyalu between two requesters,
// answering no_op/illegal opcodes locally and aborting ALU operations that never finish.
module tinyalu_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_A,
  input  logic [7:0]  req0_B,
  input  logic [2:0]  req0_op,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_A,
  input  logic [7:0]  req1_B,
  input  logic [2:0]  req1_op,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, next_state;
  logic        last_grant;
  logic        lat_port;
  logic [7:0]  lat_a, lat_b;
  logic [2:0]  lat_op;
  logic [15:0] result_q;
  logic        err_q;
  logic [7:0]  tmo_cnt;

  logic        grant0, grant1, accept, acc_port, acc_legal, timeout_hit;
  logic [7:0]  acc_a, acc_b;
  logic [2:0]  acc_op;

  // Round-robin: a lone requester always wins, a tie goes to the port that did not win last.
  always_comb begin
    grant0      = req0_valid && (!req1_valid || last_grant);
    grant1      = req1_valid && (!req0_valid || !last_grant);
    accept      = (state == IDLE) && (grant0 || grant1);
    acc_port    = grant1;
    acc_a       = grant1 ? req1_A  : req0_A;
    acc_b       = grant1 ? req1_B  : req0_B;
    acc_op      = grant1 ? req1_op : req0_op;
    acc_legal   = (acc_op >= 3'd1) && (acc_op <= 3'd4);
    timeout_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = acc_legal ? EXEC : RESP;
      EXEC: if (alu_done || timeout_hit) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = (state == IDLE) && grant0;
    req1_ready  = (state == IDLE) && grant1;
    rsp0_valid  = (state == RESP) && !lat_port;
    rsp1_valid  = (state == RESP) && lat_port;
    rsp0_result = rsp0_valid ? result_q : 16'h0000;
    rsp1_result = rsp1_valid ? result_q : 16'h0000;
    rsp0_err    = rsp0_valid && err_q;
    rsp1_err    = rsp1_valid && err_q;
    alu_start   = (state == EXEC);
    alu_A       = lat_a;
    alu_B       = lat_b;
    alu_op      = lat_op;
    busy        = (state != IDLE);
  end

  // Local ops resolve their result at accept time; ALU ops resolve it on done or timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_a      <= 8'h00;
      lat_b      <= 8'h00;
      lat_op     <= 3'd0;
      result_q   <= 16'h0000;
      err_q      <= 1'b0;
      tmo_cnt    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_a      <= acc_a;
            lat_b      <= acc_b;
            lat_op     <= acc_op;
            lat_port   <= acc_port;
            last_grant <= acc_port;
            tmo_cnt    <= 8'h00;
            result_q   <= 16'h0000;
            err_q      <= !acc_legal && (acc_op != 3'd0);
          end
        end
        EXEC: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (alu_done) begin
            result_q <= alu_result;
            err_q    <= 1'b0;
          end else if (timeout_hit) begin
            result_q <= 16'h0000;
            err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: drives both requester ports against a behavioural tinyalu, scoring each
// response from a per-port queue of results computed straight from the opcode definitions.
module tb_tinyalu_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk, reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_A, req0_B, req1_A, req1_B;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [15:0] rsp0_result, rsp1_result;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start, busy;
  logic        alu_done_m, late_done;
  wire         alu_done = alu_done_m | late_done;
  logic [15:0] alu_result;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  bit          grant_log[$];
  bit          hang;
  int          alu_lat;
  int          start_windows = 0;
  int          last_run = 0;
  logic [7:0]  acc_a, acc_b;
  logic [2:0]  acc_op;
  bit          cur_port;

  tinyalu_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one request on a port, queue its expected response, hold until accepted, then scramble.
  task automatic applyStimulus(input bit port, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op, input bit push_exp, input bit hang_exp);
    logic [16:0] e;
    int waited = 0;
    bit got = 0;
    e = {1'b0, ref_result(op, a, b)};
    if (op >= 3'd5) e[16] = 1'b1;
    if (hang_exp && op >= 3'd1 && op <= 3'd4) e = 17'h10000;
    @(posedge clk);
    #1;
    if (port == 1'b0) begin
      req0_A = a; req0_B = b; req0_op = op; req0_valid = 1'b1;
      if (push_exp) exp_q0.push_back(e);
    end else begin
      req1_A = a; req1_B = b; req1_op = op; req1_valid = 1'b1;
      if (push_exp) exp_q1.push_back(e);
    end
    while (!got && waited < 200) begin
      @(negedge clk);
      got = port ? (req1_ready == 1'b1) : (req0_ready == 1'b1);
      waited++;
    end
    checkOutput("accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (port == 1'b0) begin
      req0_valid = 1'b0; req0_A = 8'($urandom); req0_B = 8'($urandom); req0_op = 3'($urandom);
    end else begin
      req1_valid = 1'b0; req1_A = 8'($urandom); req1_B = 8'($urandom); req1_op = 3'($urandom);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
  endtask

  // Behavioural tinyalu: done pulses alu_lat cycles into a start window unless hung.
  initial begin
    int cnt;
    cnt = 0;
    alu_done_m = 1'b0;
    alu_result = 16'h0000;
    alu_lat = 1;
    forever begin
      @(posedge clk);
      #1;
      alu_done_m = 1'b0;
      if (!reset_n || !alu_start || hang) cnt = 0;
      else if (cnt >= alu_lat) begin
        alu_done_m = 1'b1;
        alu_result = ref_result(alu_op, alu_A, alu_B);
        cnt = 0;
        alu_lat = $urandom_range(0, 4);
      end else cnt++;
    end
  end

  // Monitor: scores responses, latency after done/local accept, start windows and operand stability.
  initial begin
    logic [16:0] e;
    bit start_prev, done_prev, local_pend, local_port;
    int run_len;
    start_prev = 0; done_prev = 0; local_pend = 0; local_port = 0; run_len = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        start_prev = 0; done_prev = 0; local_pend = 0; run_len = 0;
      end else begin
        if (rsp0_valid) begin
          if (exp_q0.size() == 0) checkOutput("unexpected_rsp0", 32'(rsp0_valid), 32'd0);
          else begin
            e = exp_q0.pop_front();
            checkOutput("rsp0", 32'({rsp0_err, rsp0_result}), 32'(e));
          end
        end
        if (rsp1_valid) begin
          if (exp_q1.size() == 0) checkOutput("unexpected_rsp1", 32'(rsp1_valid), 32'd0);
          else begin
            e = exp_q1.pop_front();
            checkOutput("rsp1", 32'({rsp1_err, rsp1_result}), 32'(e));
          end
        end
        if (rsp0_valid) checkOutput("rsp_both", 32'(rsp1_valid), 32'd0);
        if (busy) checkOutput("ready_while_busy", 32'({req0_ready, req1_ready}), 32'd0);
        if (local_pend) begin
          checkOutput("local_latency", 32'(local_port ? rsp1_valid : rsp0_valid), 32'd1);
          checkOutput("local_no_start", 32'(alu_start), 32'd0);
          local_pend = 0;
        end
        if (done_prev) begin
          checkOutput("start_gap", 32'(alu_start), 32'd0);
          checkOutput("done_latency", 32'(cur_port ? rsp1_valid : rsp0_valid), 32'd1);
        end
        done_prev = alu_start && alu_done;
        if (alu_start) begin
          if (!start_prev) begin
            start_windows++;
            run_len = 0;
          end
          run_len++;
          checkOutput("alu_operands", 32'({alu_op, alu_A, alu_B}), 32'({acc_op, acc_a, acc_b}));
        end else if (start_prev) last_run = run_len;
        start_prev = alu_start;
        if (req0_valid && req0_ready) begin
          acc_a = req0_A; acc_b = req0_B; acc_op = req0_op; cur_port = 1'b0;
          grant_log.push_back(1'b0);
        end else if (req1_valid && req1_ready) begin
          acc_a = req1_A; acc_b = req1_B; acc_op = req1_op; cur_port = 1'b1;
          grant_log.push_back(1'b1);
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          if (acc_op == 3'd0 || acc_op >= 3'd5) begin
            local_pend = 1;
            local_port = cur_port;
          end
        end
      end
    end
  end

  initial begin
    int w0;
    logic [3:0] g_pat;
    reset_n = 1'b0; hang = 1'b0; late_done = 1'b0;
    req0_valid = 1'b0; req0_A = 8'h00; req0_B = 8'h00; req0_op = 3'd0;
    req1_valid = 1'b0; req1_A = 8'h00; req1_B = 8'h00; req1_op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_start", 32'(alu_start), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
    checkOutput("reset_results", 32'({rsp0_result, rsp1_result}), 32'd0);
    checkOutput("reset_alu_bus", 32'({alu_op, alu_A, alu_B}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    w0 = start_windows;
    applyStimulus(1'b0, 8'h05, 8'h03, 3'd1, 1'b1, 1'b0);
    wait_drain();
    checkOutput("t1_start_windows", 32'(start_windows - w0), 32'd1);

    w0 = start_windows;
    applyStimulus(1'b1, 8'h12, 8'h34, 3'd0, 1'b1, 1'b0);
    wait_drain();
    applyStimulus(1'b1, 8'h56, 8'h78, 3'd7, 1'b1, 1'b0);
    wait_drain();
    applyStimulus(1'b1, 8'h9A, 8'hBC, 3'd5, 1'b1, 1'b0);
    wait_drain();
    checkOutput("t3_no_start", 32'(start_windows - w0), 32'd0);

    grant_log.delete();
    fork
      begin
        applyStimulus(1'b0, 8'hFF, 8'hFF, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'hFF, 8'hFF, 3'd4, 1'b1, 1'b0);
      end
      begin
        applyStimulus(1'b1, 8'hAA, 8'h55, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAA, 8'h55, 3'd3, 1'b1, 1'b0);
      end
    join
    wait_drain();
    g_pat = 4'b1111;
    for (int i = 0; i < 4 && i < grant_log.size(); i++) g_pat[3-i] = grant_log[i];
    checkOutput("t2_grant_count", 32'(grant_log.size()), 32'd4);
    checkOutput("t2_grant_order", 32'(g_pat), 32'b0101);

    hang = 1'b1;
    applyStimulus(1'b0, 8'h21, 8'h43, 3'd1, 1'b1, 1'b1);
    wait_drain();
    late_done = 1'b1;
    hang = 1'b0;
    @(negedge clk);
    checkOutput("t4_start_len", 32'(last_run), 32'(TIMEOUT));
    @(negedge clk);
    late_done = 1'b0;
    applyStimulus(1'b0, 8'h0F, 8'h33, 3'd2, 1'b1, 1'b0);
    wait_drain();

    alu_lat = 4;
    applyStimulus(1'b0, 8'h12, 8'h34, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t6_start_held", 32'(alu_start), 32'd1);
      checkOutput("t6_operands", 32'({alu_op, alu_A, alu_B}), 32'({3'd4, 8'h12, 8'h34}));
    end
    wait_drain();

    hang = 1'b1;
    applyStimulus(1'b0, 8'h77, 8'h66, 3'd4, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("t5_start", 32'(alu_start), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
    checkOutput("t5_results", 32'({rsp0_result, rsp1_result}), 32'd0);
    hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    grant_log.delete();
    fork
      applyStimulus(1'b0, 8'h01, 8'h02, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h03, 8'h04, 3'd0, 1'b1, 1'b0);
    join
    wait_drain();
    checkOutput("t5_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 1'b1), 32'd0);

    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        applyStimulus(1'b0, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, 1'b0);
      end
      for (int j = 0; j < 15; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        applyStimulus(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1, 1'b0);
      end
    join
    wait_drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
